// File: rtl/reg_file_sb.sv
// Integer register file with two combinational read ports, one write port,
// optional write-to-read forwarding, and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            rf_en,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wdata,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            hazard
);

  // Issue/writeback contract: rf_en and iss_en are single-cycle strobes taken
  // at the rising edge with no backpressure; hazard is advisory and the caller
  // must hold iss_en low while it is set.

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  logic wr_ok;
  logic iss_ok;
  logic fwd_ok;
  logic rs1_ok;
  logic rs2_ok;
  logic hit1;
  logic hit2;

  // An address is usable when it names a real register that is not the
  // hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = (int'(a) < NREGS) && !(ZERO_REG && (a == '0));
  endfunction

  assign wr_ok  = rf_en && addr_ok(rd);
  assign iss_ok = iss_en && addr_ok(iss_rd);
  assign rs1_ok = addr_ok(rs1);
  assign rs2_ok = addr_ok(rs2);

  // A write presented while reset is held never lands, so it must not forward.
  assign fwd_ok = BYPASS && rst_n && wr_ok;
  assign hit1   = fwd_ok && (rd == rs1);
  assign hit2   = fwd_ok && (rd == rs2);

  always_comb begin
    busy_nxt = busy;
    if (wr_ok) begin
      busy_nxt[rd] = 1'b0;
    end
    // A new producer supersedes the one retiring in the same cycle.
    if (iss_ok) begin
      busy_nxt[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[rd] <= wdata;
      end
      busy <= busy_nxt;
    end
  end

  assign rdata1 = !rs1_ok ? '0 : (hit1 ? wdata : regs[rs1]);
  assign rdata2 = !rs2_ok ? '0 : (hit2 ? wdata : regs[rs2]);

  assign busy1  = rs1_ok && !hit1 && busy[rs1];
  assign busy2  = rs2_ok && !hit2 && busy[rs2];
  assign hazard = (rs1_used && busy1) || (rs2_used && busy2);

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a forwarding 32-entry instance and a non-forwarding
// 24-entry instance share stimulus and are checked against an array model.
module tb_reg_file_sb;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NB_NREGS = 24;
  localparam int HW       = 2 * XLEN + 3;
  localparam int W        = 2 * HW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1, rs2, rd, iss_rd;
  logic            rs1_used, rs2_used, rf_en, iss_en;
  logic [XLEN-1:0] wdata;

  logic [XLEN-1:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
  logic            busy1_a, busy2_a, hazard_a;
  logic            busy1_b, busy2_b, hazard_b;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  logic [W-1:0]    exp_q[$];
  logic [XLEN-1:0] m_reg  [2][32];
  bit              m_busy [2][32];

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rdata1(rdata1_a), .rdata2(rdata2_a),
    .rf_en(rf_en), .rd(rd), .wdata(wdata),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .busy1(busy1_a), .busy2(busy2_a), .hazard(hazard_a)
  );

  reg_file_sb #(.NREGS(NB_NREGS), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rdata1(rdata1_b), .rdata2(rdata2_b),
    .rf_en(rf_en), .rd(rd), .wdata(wdata),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .busy1(busy1_b), .busy2(busy2_b), .hazard(hazard_b)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model
  function automatic int nregs_of(int i);
    return (i == 0) ? 32 : NB_NREGS;
  endfunction

  function automatic bit legal(int i, int a);
    return (a < nregs_of(i)) && (a != 0);
  endfunction

  function automatic bit fwd(int i, int a);
    return (i == 0) && (rst_n === 1'b1) && (rf_en === 1'b1) &&
           legal(i, int'(rd)) && (int'(rd) == a);
  endfunction

  function automatic logic [XLEN-1:0] m_read(int i, int a);
    if (!legal(i, a)) return '0;
    if (fwd(i, a)) return wdata;
    return m_reg[i][a];
  endfunction

  function automatic bit m_busy_out(int i, int a);
    return legal(i, a) && !fwd(i, a) && m_busy[i][a];
  endfunction

  function automatic logic [HW-1:0] m_out(int i);
    bit b1;
    bit b2;
    b1 = m_busy_out(i, int'(rs1));
    b2 = m_busy_out(i, int'(rs2));
    return {m_read(i, int'(rs1)), m_read(i, int'(rs2)), b1, b2,
            (rs1_used && b1) || (rs2_used && b2)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int a = 0; a < 32; a++) begin
          m_reg[i][a]  <= '0;
          m_busy[i][a] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rf_en && legal(i, int'(rd))) begin
          m_reg[i][rd]  <= wdata;
          m_busy[i][rd] <= 1'b0;
        end
        if (iss_en && legal(i, int'(iss_rd))) begin
          m_busy[i][iss_rd] <= 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard: every cycle, mid-phase
  always @(negedge clk) begin
    if (chk_on) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      exp_q.push_back({m_out(0), m_out(1)});
      act = {rdata1_a, rdata2_a, busy1_a, busy2_a, hazard_a,
             rdata1_b, rdata2_b, busy1_b, busy2_b, hazard_b};
      exp = exp_q.pop_front();
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t got %h expected %h", $time, act, exp);
      end
    end
  end

  task automatic check_lit(input string name, input logic [XLEN-1:0] act,
                           input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- drivers
  task automatic idle();
    rf_en    = 1'b0;
    iss_en   = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus
  initial begin
    rst_n  = 1'b0;
    idle();
    rs1    = 5'd5;
    rs2    = 5'd31;
    rd     = '0;
    iss_rd = '0;
    wdata  = '0;
    next();
    chk_on = 1'b1;
    next();
    check_lit("reset_rdata1", rdata1_a, 32'h0);
    check_lit("reset_rdata2", rdata2_a, 32'h0);
    check_lit("reset_busy1",  {31'h0, busy1_a}, 32'h0);
    check_lit("reset_busy2",  {31'h0, busy2_a}, 32'h0);
    check_lit("reset_hazard", {31'h0, hazard_a}, 32'h0);
    #2 rst_n = 1'b1;
    next();

    // write then read, and the zero register
    rf_en = 1'b1; rd = 5'd7; wdata = 32'hDEADBEEF;
    next();
    rf_en = 1'b0; rs1 = 5'd7; #1;
    check_lit("wr_rd7_a", rdata1_a, 32'hDEADBEEF);
    check_lit("wr_rd7_b", rdata1_b, 32'hDEADBEEF);
    check_lit("model_rd7", m_reg[0][7], 32'hDEADBEEF);
    rf_en = 1'b1; rd = 5'd0; wdata = 32'h1234; rs2 = 5'd0; #1;
    check_lit("zero_fwd_a", rdata2_a, 32'h0);
    next();
    rf_en = 1'b0; #1;
    check_lit("zero_rd_a", rdata2_a, 32'h0);
    check_lit("zero_rd_b", rdata2_b, 32'h0);

    // forwarding
    rf_en = 1'b1; rd = 5'd3; wdata = 32'hA5A5A5A5; rs1 = 5'd3; #1;
    check_lit("bypass_a", rdata1_a, 32'hA5A5A5A5);
    check_lit("nobypass_old_b", rdata1_b, 32'h0);
    next();
    rf_en = 1'b0; #1;
    check_lit("nobypass_new_b", rdata1_b, 32'hA5A5A5A5);

    // RAW through the scoreboard
    iss_en = 1'b1; iss_rd = 5'd9;
    next();
    iss_en = 1'b0; rs2 = 5'd9; rs2_used = 1'b1; #1;
    check_lit("raw_busy2_a",  {31'h0, busy2_a}, 32'h1);
    check_lit("raw_hazard_a", {31'h0, hazard_a}, 32'h1);
    check_lit("raw_hazard_b", {31'h0, hazard_b}, 32'h1);
    rf_en = 1'b1; rd = 5'd9; wdata = 32'h99; #1;
    check_lit("wb_hazard_a", {31'h0, hazard_a}, 32'h0);
    check_lit("wb_hazard_b", {31'h0, hazard_b}, 32'h1);
    next();
    rf_en = 1'b0; #1;
    check_lit("wb_busy2_a",   {31'h0, busy2_a}, 32'h0);
    check_lit("wb_hazard_b2", {31'h0, hazard_b}, 32'h0);
    check_lit("wb_data_a",    rdata2_a, 32'h99);
    rs2_used = 1'b0;

    // set/clear collision: set wins
    iss_en = 1'b1; iss_rd = 5'd4;
    next();
    rf_en = 1'b1; rd = 5'd4; wdata = 32'h44; rs1 = 5'd4; rs1_used = 1'b1; #1;
    check_lit("coll_fwd_busy1_a", {31'h0, busy1_a}, 32'h0);
    check_lit("coll_busy1_b",     {31'h0, busy1_b}, 32'h1);
    next();
    rf_en = 1'b0; iss_en = 1'b0; #1;
    check_lit("coll_busy1_a",  {31'h0, busy1_a}, 32'h1);
    check_lit("coll_hazard_a", {31'h0, hazard_a}, 32'h1);
    rs1_used = 1'b0; #1;
    check_lit("coll_unused_hazard_a", {31'h0, hazard_a}, 32'h0);
    check_lit("coll_data_a", rdata1_a, 32'h44);

    // address beyond NREGS on the 24-entry instance
    rf_en = 1'b1; rd = 5'd30; wdata = 32'h30303030;
    iss_en = 1'b1; iss_rd = 5'd30; rs1 = 5'd30; #1;
    check_lit("hi_fwd_a", rdata1_a, 32'h30303030);
    check_lit("hi_rd_b",  rdata1_b, 32'h0);
    next();
    idle(); #1;
    check_lit("hi_data_a",  rdata1_a, 32'h30303030);
    check_lit("hi_busy1_a", {31'h0, busy1_a}, 32'h1);
    check_lit("hi_busy1_b", {31'h0, busy1_b}, 32'h0);
    iss_en = 1'b1; iss_rd = 5'd0;
    next();
    iss_en = 1'b0; rs1 = 5'd0; rs1_used = 1'b1; #1;
    check_lit("zero_busy1_a", {31'h0, busy1_a}, 32'h0);
    check_lit("zero_hazard_a", {31'h0, hazard_a}, 32'h0);

    // asynchronous reset between edges
    iss_en = 1'b1; iss_rd = 5'd9;
    next();
    idle(); rs1 = 5'd7; rs2 = 5'd9; rs2_used = 1'b1; #1;
    check_lit("pre_rst_data_a", rdata1_a, 32'hDEADBEEF);
    check_lit("pre_rst_busy2_a", {31'h0, busy2_a}, 32'h1);
    rst_n = 1'b0; #1;
    check_lit("mid_rst_data_a",   rdata1_a, 32'h0);
    check_lit("mid_rst_busy2_a",  {31'h0, busy2_a}, 32'h0);
    check_lit("mid_rst_hazard_a", {31'h0, hazard_a}, 32'h0);
    check_lit("mid_rst_data_b",   rdata1_b, 32'h0);
    next();
    #2 rst_n = 1'b1;

    // randomized traffic with occasional reset pulses
    repeat (3000) begin
      next();
      if ($urandom_range(0, 1) == 1) begin
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        iss_rd = 5'($urandom_range(0, 7));
      end else begin
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        iss_rd = 5'($urandom_range(0, 31));
      end
      rs1_used = 1'($urandom_range(0, 1));
      rs2_used = 1'($urandom_range(0, 1));
      rf_en    = 1'($urandom_range(0, 1));
      iss_en   = 1'($urandom_range(0, 1));
      wdata    = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end

    idle();
    repeat (2) next();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
